// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if: operand/result valid-ready bus between fetch, the adder and writeback.
interface pipelined_cla_adder_if #(
   parameter int NBITS = 32
);
   logic             in_valid, in_ready, cin, sub;
   logic [NBITS-1:0] a_in, b_in, sum;
   logic             out_valid, out_ready, cout, ovf, zero;
   modport master (
      output in_valid, a_in, b_in, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero
   );
   modport slave (
      input  in_valid, a_in, b_in, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: NBITS adder/subtractor built from BLOCK-bit lookahead slices, one slice per
// pipeline stage, carry registered between stages, whole-pipe stall on output back-pressure.
module pipelined_cla_adder #(
   parameter int NBITS = 32,
   parameter int BLOCK = 8
) (
   input logic                  clk,
   input logic                  rst,
   pipelined_cla_adder_if.slave bus
);
   localparam int STAGES = NBITS / BLOCK;
   if (NBITS % BLOCK != 0) begin : g_bad_split
      $error("NBITS must be a multiple of BLOCK");
   end
   logic              advance, ld, ovf_q, ovf_d, zero_q, zero_d;
   logic [STAGES-1:0] v_q, v_d, c_q, c_d, vi, ci;
   logic [NBITS-1:0]  a_q [STAGES], a_d [STAGES], b_q [STAGES], b_d [STAGES];
   logic [NBITS-1:0]  s_q [STAGES], s_d [STAGES], ai [STAGES], bi [STAGES], si [STAGES];
   logic [NBITS-1:0]  sn;
   logic [BLOCK-1:0]  p, g;
   logic [BLOCK:0]    cr;
   // Every carry is a flat sum of generate/propagate products, so no carry waits on its neighbour.
   function automatic logic [BLOCK:0] carries(input logic [BLOCK-1:0] pp, gg, input logic c0);
      logic [BLOCK:0] c;
      logic           t;
      c = '0;
      t = 1'b0;
      c[0] = c0;
      for (int i = 0; i < BLOCK; i++) begin
         c[i+1] = c0;
         for (int j = 0; j <= i; j++) c[i+1] = c[i+1] & pp[j];
         for (int j = 0; j <= i; j++) begin
            t = gg[j];
            for (int k = j + 1; k <= i; k++) t = t & pp[k];
            c[i+1] = c[i+1] | t;
         end
      end
      return c;
   endfunction
   always_comb begin
      advance = !v_q[STAGES-1] | bus.out_ready;
      vi = '0;
      ci = '0;
      vi[0] = bus.in_valid;
      ci[0] = bus.sub | bus.cin;
      ai[0] = bus.a_in;
      bi[0] = bus.sub ? ~bus.b_in : bus.b_in;
      si[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         vi[k] = v_q[k-1];
         ci[k] = c_q[k-1];
         ai[k] = a_q[k-1];
         bi[k] = b_q[k-1];
         si[k] = s_q[k-1];
      end
      v_d = advance ? vi : v_q;
      p = '0;
      g = '0;
      cr = '0;
      sn = '0;
      ld = 1'b0;
      // Data registers only load real beats, so outputs keep their last value across bubbles.
      for (int k = 0; k < STAGES; k++) begin
         p = ai[k][k*BLOCK +: BLOCK] ^ bi[k][k*BLOCK +: BLOCK];
         g = ai[k][k*BLOCK +: BLOCK] & bi[k][k*BLOCK +: BLOCK];
         cr = carries(p, g, ci[k]);
         sn = si[k];
         sn[k*BLOCK +: BLOCK] = p ^ cr[BLOCK-1:0];
         ld = advance & vi[k];
         a_d[k] = ld ? ai[k] : a_q[k];
         b_d[k] = ld ? bi[k] : b_q[k];
         s_d[k] = ld ? sn : s_q[k];
         c_d[k] = ld ? cr[BLOCK] : c_q[k];
      end
      ovf_d = ld ? cr[BLOCK] ^ cr[BLOCK-1] : ovf_q;
      zero_d = ld ? ~|sn : zero_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         c_q <= '0;
         ovf_q <= 1'b0;
         zero_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         c_q <= c_d;
         ovf_q <= ovf_d;
         zero_q <= zero_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
      end
   end
   assign bus.in_ready = advance;
   assign bus.out_valid = v_q[STAGES-1];
   assign bus.sum = s_q[STAGES-1];
   assign bus.cout = c_q[STAGES-1];
   assign bus.ovf = ovf_q;
   assign bus.zero = zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed and scoreboarded checks of the pipelined adder in three
// width/block configurations (32/8, 16/16, 64/4).
module tb_pipelined_cla_adder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   pipelined_cla_adder_if #(.NBITS(32)) i32 ();
   pipelined_cla_adder_if #(.NBITS(16)) i16 ();
   pipelined_cla_adder_if #(.NBITS(64)) i64 ();
   pipelined_cla_adder #(.NBITS(32), .BLOCK(8))  d32 (.clk(clk), .rst(rst), .bus(i32));
   pipelined_cla_adder #(.NBITS(16), .BLOCK(16)) d16 (.clk(clk), .rst(rst), .bus(i16));
   pipelined_cla_adder #(.NBITS(64), .BLOCK(4))  d64 (.clk(clk), .rst(rst), .bus(i64));

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // {cout, ovf, sum}; overflow from operand/result signs rather than carries
   function automatic logic [65:0] model(input int n, input logic [63:0] a, b, input logic ci, sb);
      logic [63:0] m, am, bb, s;
      logic [64:0] f;
      m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      am = a & m;
      bb = (sb ? ~b : b) & m;
      f = {1'b0, am} + {1'b0, bb} + {64'd0, sb | ci};
      s = f[63:0] & m;
      return {f[n], (am[n-1] == bb[n-1]) && (s[n-1] != am[n-1]), s};
   endfunction

   task automatic beat32(input string tag, input logic [31:0] a, b, input logic ci, sb,
                         input logic [31:0] es, input logic ec, eo);
      int n;
      i32.a_in = a;
      i32.b_in = b;
      i32.cin = ci;
      i32.sub = sb;
      i32.in_valid = 1'b1;
      i32.out_ready = 1'b1;
      #1;
      chk({tag, "_rdy"}, i32.in_ready, 1'b1);
      @(negedge clk);
      i32.in_valid = 1'b0;
      n = 1;
      while (!i32.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, 4);
      chk({tag, "_res"}, {i32.cout, i32.ovf, 32'h0, i32.sum}, {ec, eo, 32'h0, es});
      chk({tag, "_zero"}, i32.zero, es == 32'h0);
   endtask

   task automatic stream32(input string tag, input int n, input int stall_len);
      logic [65:0] q[$];
      logic [65:0] e, held;
      int sent = 0, got = 0, first = -1, last = -1, stall_left = 0;
      bit stalled = 0, acc = 0;
      for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
         @(negedge clk);
         if (!i32.in_valid || acc) begin
            i32.in_valid = sent < n;
            i32.a_in = $urandom;
            i32.b_in = $urandom;
            i32.cin = 1'($urandom_range(0, 1));
            i32.sub = 1'($urandom_range(0, 1));
         end
         if (!stalled && i32.out_valid && stall_len > 0) begin
            stalled = 1;
            stall_left = stall_len;
            held = {i32.cout, i32.ovf, i32.zero, 31'h0, i32.sum};
         end
         i32.out_ready = stall_left == 0;
         #1;
         acc = 0;
         if (stall_left > 0) begin
            chk({tag, "_stall_rdy"}, i32.in_ready, 1'b0);
            if (stall_left < stall_len)
               chk({tag, "_stall_hold"}, {i32.cout, i32.ovf, i32.zero, 31'h0, i32.sum}, held);
            stall_left--;
         end
         if (i32.out_valid && i32.out_ready) begin
            chk({tag, "_pending"}, q.size() > 0, 1'b1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk({tag, "_res"}, {i32.cout, i32.ovf, 32'h0, i32.sum}, e);
               chk({tag, "_zero"}, i32.zero, e[63:0] == 64'h0);
            end
            got++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (i32.in_valid && i32.in_ready) begin
            q.push_back(model(32, {32'h0, i32.a_in}, {32'h0, i32.b_in}, i32.cin, i32.sub));
            sent++;
            acc = 1;
         end
      end
      @(negedge clk);
      i32.in_valid = 1'b0;
      chk({tag, "_count"}, got, n);
      chk({tag, "_left"}, q.size(), 0);
      if (stall_len == 0) chk({tag, "_consecutive"}, last - first, n - 1);
   endtask

   initial begin
      logic [65:0] q16[$], q64[$], e;
      int sent, got, lat, seen;
      {i32.in_valid, i32.a_in, i32.b_in, i32.cin, i32.sub, i32.out_ready} = '0;
      {i16.in_valid, i16.a_in, i16.b_in, i16.cin, i16.sub, i16.out_ready} = '0;
      {i64.in_valid, i64.a_in, i64.b_in, i64.cin, i64.sub, i64.out_ready} = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_flags", {i32.out_valid, i32.in_ready, i32.cout, i32.ovf, i32.zero}, 5'b01000);
      chk("reset_sum", i32.sum, 32'h0);
      beat32("max_plus_one", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      beat32("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      beat32("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      beat32("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
      beat32("add_cin", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      beat32("add_mixed", 32'h0F0F_00FF, 32'h00F1_0001, 1'b0, 1'b0, 32'h1000_0100, 1'b0, 1'b0);
      stream32("stream", 10, 0);
      stream32("bp", 6, 5);
      // three beats in flight, reset one cycle before the first would emerge
      i32.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i32.a_in = 32'hA5A5_0000 + k;
         i32.b_in = 32'h0101_0101;
         i32.in_valid = 1'b1;
         @(negedge clk);
      end
      i32.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_async_flags", {i32.out_valid, i32.in_ready, i32.cout, i32.ovf, i32.zero}, 5'b01000);
      chk("rst_async_sum", i32.sum, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (i32.out_valid) seen++;
      end
      chk("rst_no_result", seen, 0);
      chk("rst_ready", i32.in_ready, 1'b1);
      beat32("after_rst", 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, 1'b0);
      // one-stage configuration
      sent = 0; got = 0; lat = -1;
      i16.out_ready = 1'b1;
      for (int cyc = 0; cyc < 1100 && got < 1000; cyc++) begin
         @(negedge clk);
         i16.in_valid = sent < 1000;
         i16.a_in = 16'($urandom);
         i16.b_in = 16'($urandom);
         i16.cin = 1'($urandom_range(0, 1));
         i16.sub = 1'($urandom_range(0, 1));
         #1;
         if (i16.out_valid) begin
            if (lat < 0) lat = cyc;
            chk("s16_pending", q16.size() > 0, 1'b1);
            if (q16.size() > 0) begin
               e = q16.pop_front();
               chk("s16_res", {i16.cout, i16.ovf, 48'h0, i16.sum}, e);
               chk("s16_zero", i16.zero, e[63:0] == 64'h0);
            end
            got++;
         end
         if (i16.in_valid && i16.in_ready) begin
            q16.push_back(model(16, {48'h0, i16.a_in}, {48'h0, i16.b_in}, i16.cin, i16.sub));
            sent++;
         end
      end
      i16.in_valid = 1'b0;
      chk("s16_lat", lat, 1);
      chk("s16_count", got, 1000);
      // sixteen-stage configuration
      sent = 0; got = 0; lat = -1;
      i64.out_ready = 1'b1;
      for (int cyc = 0; cyc < 1100 && got < 1000; cyc++) begin
         @(negedge clk);
         i64.in_valid = sent < 1000;
         i64.a_in = {$urandom, $urandom};
         i64.b_in = {$urandom, $urandom};
         i64.cin = 1'($urandom_range(0, 1));
         i64.sub = 1'($urandom_range(0, 1));
         #1;
         if (i64.out_valid) begin
            if (lat < 0) lat = cyc;
            chk("s64_pending", q64.size() > 0, 1'b1);
            if (q64.size() > 0) begin
               e = q64.pop_front();
               chk("s64_res", {i64.cout, i64.ovf, i64.sum}, e);
               chk("s64_zero", i64.zero, e[63:0] == 64'h0);
            end
            got++;
         end
         if (i64.in_valid && i64.in_ready) begin
            q64.push_back(model(64, i64.a_in, i64.b_in, i64.cin, i64.sub));
            sent++;
         end
      end
      i64.in_valid = 1'b0;
      chk("s64_lat", lat, 16);
      chk("s64_count", got, 1000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
